// File: rtl/enc_event_fifo.sv
// Change-detecting capture FIFO behind an 8-to-3 priority encoder.
// A new {code_vld, code} pair is queued whenever it differs from the last pair seen while enabled.
module enc_event_fifo #(
    parameter int DEPTH  = 4,
    parameter int CODE_W = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [CODE_W-1:0]          code,
    input  logic                       code_vld,
    input  logic                       clr_ovf,
    output logic [CODE_W-1:0]          out_code,
    output logic                       out_any,
    output logic                       out_vld,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       ovf
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int ENTRY_W = CODE_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [ENTRY_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;
    logic               r_ovf;
    logic [ENTRY_W-1:0] r_last;

    logic [ENTRY_W-1:0] w_pair;
    logic [ENTRY_W-1:0] w_head;
    logic               w_event;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push;
    logic               w_drop;

    // Output handshake: the head entry transfers on any rising edge where
    // out_vld and out_rdy are both high; out_vld never depends on out_rdy.
    assign w_pair  = {code_vld, code};
    assign w_event = en && (w_pair != r_last);
    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);
    assign w_pop   = !w_empty && out_rdy;
    // A pop in the same edge frees the slot, so a full FIFO can still accept.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    assign w_head   = r_mem[r_rd_ptr];
    assign out_code = w_head[CODE_W-1:0];
    assign out_any  = w_head[CODE_W];
    assign out_vld  = !w_empty;
    assign count    = r_count;
    assign ovf      = r_ovf;

    // Storage carries no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wr_ptr] <= w_pair;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_last   <= '0;
        end else begin
            if (w_event) begin
                r_last <= w_pair;
            end
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
            // Setting on a drop takes priority over a same-cycle clear.
            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_enc_event_fifo.sv
// Directed bench for enc_event_fifo: expected entries are queued by the stimulus
// and checked by an independent monitor whenever the head entry is consumed.
module tb_enc_event_fifo;

    localparam int DEPTH  = 4;
    localparam int CODE_W = 3;

    logic              clk;
    logic              rst;
    logic              en;
    logic [CODE_W-1:0] code;
    logic              code_vld;
    logic              clr_ovf;
    logic [CODE_W-1:0] out_code;
    logic              out_any;
    logic              out_vld;
    logic              out_rdy;
    logic [2:0]        count;
    logic              ovf;

    int tests;
    int fails;
    logic [CODE_W:0] exp_q[$];

    enc_event_fifo #(.DEPTH(DEPTH), .CODE_W(CODE_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .code     (code),
        .code_vld (code_vld),
        .clr_ovf  (clr_ovf),
        .out_code (out_code),
        .out_any  (out_any),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .count    (count),
        .ovf      (ovf)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int actual, input int expected);
        tests++;
        if (actual != expected) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Drive one cycle of inputs, then return 1 time unit after the next rising edge.
    task automatic step(input logic s_en, input logic s_vld, input logic [CODE_W-1:0] s_code,
                        input logic s_rdy, input logic s_clr);
        en       = s_en;
        code_vld = s_vld;
        code     = s_code;
        out_rdy  = s_rdy;
        clr_ovf  = s_clr;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_entry(input logic any, input logic [CODE_W-1:0] c);
        exp_q.push_back({any, c});
    endtask

    // Monitor: a transfer happens at the coming edge when out_vld && out_rdy now.
    always @(negedge clk) begin
        if (!rst && out_vld && out_rdy) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL pop_unexpected: got any=%0d code=%0d, expected no entry", out_any, out_code);
            end else begin
                logic [CODE_W:0] e;
                e = exp_q.pop_front();
                if ({out_any, out_code} != e) begin
                    fails++;
                    $display("FAIL pop_data: got any=%0d code=%0d, expected any=%0d code=%0d",
                             out_any, out_code, e[CODE_W], e[CODE_W-1:0]);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst = 1'b1;
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 3'd0, 1'b0, 1'b0);
        rst = 1'b0;
        check("reset_count", count, 0);
        check("reset_out_vld", out_vld, 0);
        check("reset_ovf", ovf, 0);

        // Basic push: a held pair yields one entry
        expect_entry(1'b1, 3'd7);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 3'd7, 1'b0, 1'b0);
        check("basic_count", count, 1);
        check("basic_out_vld", out_vld, 1);
        check("basic_out_code", out_code, 7);
        check("basic_out_any", out_any, 1);
        step(1'b1, 1'b1, 3'd7, 1'b1, 1'b0);
        check("basic_drained", count, 0);

        // Index 0 versus no input
        expect_entry(1'b1, 3'd0);
        step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        expect_entry(1'b0, 3'd0);
        step(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
        check("idx0_count", count, 2);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);
        check("idx0_drained", count, 0);

        // Overflow: fifth distinct pair is dropped
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) expect_entry(1'b1, 3'(i));
            step(1'b1, 1'b1, 3'(i), 1'b0, 1'b0);
        end
        check("ovf_count", count, 4);
        check("ovf_set", ovf, 1);
        step(1'b0, 1'b1, 3'd5, 1'b0, 1'b1);
        check("ovf_clear", ovf, 0);
        // Drop and clear in the same cycle: set wins
        step(1'b1, 1'b1, 3'd6, 1'b0, 1'b1);
        check("ovf_set_wins", ovf, 1);
        check("ovf_drop_count", count, 4);
        step(1'b0, 1'b1, 3'd6, 1'b0, 1'b1);
        check("ovf_clear2", ovf, 0);

        // Full with simultaneous pop: new entry lands at the wrapped tail
        expect_entry(1'b0, 3'd7);
        step(1'b1, 1'b0, 3'd7, 1'b1, 1'b0);
        check("fullpop_count", count, 4);
        check("fullpop_ovf", ovf, 0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 3'd7, 1'b1, 1'b0);
        check("fullpop_drained", count, 0);

        // Enable gating
        expect_entry(1'b1, 3'd1);
        step(1'b1, 1'b1, 3'd1, 1'b0, 1'b0);
        check("gate_first", count, 1);
        step(1'b0, 1'b1, 3'd1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd5, 1'b1, 1'b0);
        step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        check("gate_pop_while_disabled", count, 0);
        expect_entry(1'b1, 3'd2);
        step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        step(1'b1, 1'b1, 3'd2, 1'b0, 1'b0);
        check("gate_single_event", count, 1);
        step(1'b0, 1'b1, 3'd2, 1'b1, 1'b0);
        check("gate_drained", count, 0);

        // Reset mid-operation discards entries and overrides push/pop
        for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 3'(i), 1'b0, 1'b0);
        check("midrst_count_before", count, 3);
        exp_q.delete();
        rst = 1'b1;
        step(1'b1, 1'b0, 3'd5, 1'b1, 1'b0);
        rst = 1'b0;
        check("midrst_count", count, 0);
        check("midrst_out_vld", out_vld, 0);
        check("midrst_ovf", ovf, 0);
        // First cycle after reset: {1,0} is an event
        expect_entry(1'b1, 3'd0);
        step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        check("post_rst_event", count, 1);
        step(1'b1, 1'b1, 3'd0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 3'd0, 1'b0, 1'b0);
        check("final_count", count, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/enc_event_fifo.md
ENC_EVENT_FIFO -- requirements
Module: enc_event_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 SHALL have parameter CODE_W, default 3, width of encoded code.
REQ-003 Port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port en  input  1  capture enable; mirrors the upstream encoder enable.
REQ-006 Port code  input  CODE_W  priority-encoded index from the upstream 8-to-3 encoder.
REQ-007 Port code_vld  input  1  high when any encoder input bit is set (OR of the 8 inputs); separates index 0 from no input.
REQ-008 Port clr_ovf  input  1  clears the overflow flag.
REQ-009 Port out_code  output  CODE_W  code field of the FIFO head entry.
REQ-010 Port out_any  output  1  code_vld field of the FIFO head entry.
REQ-011 Port out_vld  output  1  FIFO non-empty.
REQ-012 Port out_rdy  input  1  consumer accepts the head entry.
REQ-013 Port count  output  clog2(DEPTH)+1  number of stored entries.
REQ-014 Port ovf  output  1  sticky overflow flag.

Function
REQ-015 Event: a sampled pair {code_vld, code} differs from the last-seen register while en=1 at a rising edge.
REQ-016 On every event, the last-seen register SHALL load the sampled pair, whether or not the pair is stored.
REQ-017 The last-seen register SHALL hold its value while en=0; no events are detected while en=0.
REQ-018 Push: an event with the FIFO not full, or with the FIFO full and a pop in the same cycle; writes {code_vld, code} at the write pointer.
REQ-019 Pop: out_vld=1 and out_rdy=1 at a rising edge; advances the read pointer.
REQ-020 Pop SHALL proceed independently of en.
REQ-021 Latency: an entry pushed into an empty FIFO at edge N SHALL appear on out_vld/out_code/out_any after edge N, with no extra cycle.
REQ-022 out_code/out_any SHALL be driven from the head storage entry; values are don't-care while out_vld=0.
REQ-023 Simultaneous push and pop SHALL leave count unchanged; with count 0 a pop cannot occur, so the push increments count.
REQ-024 Drop: an event with count=DEPTH and no pop that cycle SHALL NOT store, SHALL set ovf, and SHALL leave FIFO contents unchanged.
REQ-025 Write and read pointers SHALL be clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-026 count SHALL never exceed DEPTH or underflow below 0.
REQ-027 clr_ovf=1 SHALL clear ovf at the next edge.
REQ-028 If clr_ovf=1 and a drop occur in the same cycle, the set SHALL win: ovf=1.
REQ-029 Entries SHALL leave in push order (FIFO).

Reset
REQ-030 While rst=1 at an edge: pointers=0, count=0, out_vld=0, ovf=0, last-seen register={0, 0}.
REQ-031 Reset SHALL override any push, pop, or clr_ovf in the same cycle.
REQ-032 Reset mid-operation SHALL discard all stored entries.
REQ-033 In the first cycle after reset, an input {1, 0} SHALL count as an event.
REQ-034 Storage RAM contents need not be reset.

Verification
REQ-035 Basic push: reset; en=1, out_rdy=0; drive code_vld=1, code=7 for 3 cycles -> exactly one entry; count=1; out_vld=1; out_code=7; out_any=1.
REQ-036 Index 0 versus no input: {1,0} then {0,0} -> two entries, popped in order as (any=1, code=0) then (any=0, code=0).
REQ-037 Overflow: DEPTH=4, out_rdy=0; apply 5 distinct pairs -> count=4; ovf=1; the first 4 pairs are retained. Pulse clr_ovf -> ovf=0.
REQ-038 Full with simultaneous pop: count=4, out_rdy=1, new event in the same cycle -> count stays 4; ovf stays 0; the new entry lands at the tail after pointer wrap.
REQ-039 Enable gating: en=0 while code changes 1->5->2, then en=1 holding code 2 -> a single event (2) is stored; the draining pop during en=0 still works.
REQ-040 Reset mid-operation: count=3; assert rst one cycle together with out_rdy=1 and a new event -> count=0; out_vld=0; ovf=0.
